// File: rtl/locked_reg_pkg.sv
// Shared types and constants for the lockable register bank access logic.
// Latency: n/a (package only).
// Backpressure: n/a.
package locked_reg_pkg;

    // Read-port sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Violation telemetry counter width and saturation value
    localparam int                    VIOL_CNT_W   = 8;
    localparam logic [VIOL_CNT_W-1:0] VIOL_CNT_MAX = 8'hFF;

    // Registers 4..7 hold secrets in the default bank layout
    localparam logic [7:0] SECRET_MASK_DEFAULT = 8'hF0;

endpackage

// File: rtl/lock_access_check.sv
// Access policy for one register index: scan, range and lock/debug checks.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated whenever the caller samples it.
//
// Ports:
//   addr           register index under test
//   lock_status    per-register lock bits from the bank
//   scan_mode      scan active, every access is denied
//   debug_unlocked debug authorisation, overrides lock on secret registers
//   deny           access must be refused
//   count_viol     refusal is a security event (scan or lock), not a range error
//   oob            index is beyond the populated bank
module lock_access_check
    import locked_reg_pkg::*;
#(
    parameter int                    NUM_REGS    = 8,
    parameter int                    ADDR_W      = 3,
    parameter logic [NUM_REGS-1:0]   SECRET_MASK = NUM_REGS'(SECRET_MASK_DEFAULT)
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [NUM_REGS-1:0] lock_status,
    input  logic                scan_mode,
    input  logic                debug_unlocked,
    output logic                deny,
    output logic                count_viol,
    output logic                oob
);

    logic lock_hit;

    // Index decoded by compare so an out-of-range addr never indexes the vectors
    always_comb begin
        lock_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                lock_hit = SECRET_MASK[i] && lock_status[i] && !debug_unlocked;
            end
        end
    end

    assign oob        = (int'(addr) >= NUM_REGS);
    assign deny       = scan_mode || oob || lock_hit;
    // Range errors are bus mistakes rather than attacks, so they are not counted
    assign count_viol = scan_mode || lock_hit;

endmodule

// File: rtl/locked_reg_read_port.sv
// Read responder for the lockable config bank: select register, apply policy, count denials.
// Latency: accept at edge N, response registered at edge N+1, visible to consumer at edge N+2.
// Backpressure: one request in flight; req_ready low until the response handshake completes.
//
// Ports:
//   Clk, resetn                       clock (rising edge), async active-low reset
//   req_valid/req_ready/req_addr      read request handshake
//   rsp_valid/rsp_ready/rsp_data/err  read response handshake, data 0 on error
//   reg_data                          flattened bank contents, reg i at [i*DATA_W +: DATA_W]
//   lock_status                       per-register lock bits
//   scan_mode, debug_unlocked         access policy controls
//   clr_viol                          clears the telemetry counter and sticky flag
//   viol_count, viol_sticky           denied-read telemetry
module locked_reg_read_port
    import locked_reg_pkg::*;
#(
    parameter int                  NUM_REGS    = 8,
    parameter int                  DATA_W      = 16,
    parameter int                  ADDR_W      = 3,
    parameter logic [NUM_REGS-1:0] SECRET_MASK = NUM_REGS'(SECRET_MASK_DEFAULT)
) (
    input  logic                       Clk,
    input  logic                       resetn,
    input  logic                       req_valid,
    input  logic [ADDR_W-1:0]          req_addr,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    input  logic                       rsp_ready,
    input  logic [NUM_REGS*DATA_W-1:0] reg_data,
    input  logic [NUM_REGS-1:0]        lock_status,
    input  logic                       scan_mode,
    input  logic                       debug_unlocked,
    input  logic                       clr_viol,
    output logic [VIOL_CNT_W-1:0]      viol_count,
    output logic                       viol_sticky
);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   rd_data;
    logic                deny;
    logic                count_viol;
    logic                oob;

    lock_access_check #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_W      (ADDR_W),
        .SECRET_MASK (SECRET_MASK)
    ) u_check (
        .addr           (addr_q),
        .lock_status    (lock_status),
        .scan_mode      (scan_mode),
        .debug_unlocked (debug_unlocked),
        .deny           (deny),
        .count_viol     (count_viol),
        .oob            (oob)
    );

    // Register select; out-of-range indices read as zero
    always_comb begin
        rd_data = '0;
        if (!oob) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == ADDR_W'(i)) begin
                    rd_data = reg_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Ready is a pure state decode, so it never depends on request inputs
    assign req_ready = (state == IDLE);

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            viol_count  <= '0;
            viol_sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    // Policy is sampled here only; later lock/debug changes leave the response alone
                    rsp_data  <= deny ? '0 : rd_data;
                    rsp_err   <= deny;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Scan entry scrubs a response still waiting for the consumer
                    if (scan_mode) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Clear wins over a same-cycle denial
            if (clr_viol) begin
                viol_count  <= '0;
                viol_sticky <= 1'b0;
            end else if (state == FETCH && count_viol) begin
                viol_sticky <= 1'b1;
                if (viol_count != VIOL_CNT_MAX) begin
                    viol_count <= viol_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_locked_reg_read_port.sv
// Self-checking bench for locked_reg_read_port with a response scoreboard.
// Latency: checks accept->valid spacing on every read.
// Backpressure: exercises held responses with rsp_ready low.
module tb_locked_reg_read_port;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic         Clk;
    logic         resetn;
    logic         req_valid;
    logic [2:0]   req_addr;
    logic         req_ready;
    logic         rsp_valid;
    logic [15:0]  rsp_data;
    logic         rsp_err;
    logic         rsp_ready;
    logic [127:0] reg_data;
    logic [7:0]   lock_status;
    logic         scan_mode;
    logic         debug_unlocked;
    logic         clr_viol;
    logic [7:0]   viol_count;
    logic         viol_sticky;

    // Second instance with a partially populated bank for range checks
    logic         b_req_valid;
    logic [2:0]   b_req_addr;
    logic         b_req_ready;
    logic         b_rsp_valid;
    logic [15:0]  b_rsp_data;
    logic         b_rsp_err;
    logic         b_rsp_ready;
    logic [95:0]  b_reg_data;
    logic [5:0]   b_lock;
    logic [7:0]   b_viol_count;
    logic         b_viol_sticky;

    logic [15:0]  regs [8];
    logic [7:0]   mask_tb;
    exp_t         sb [$];
    int           exp_cnt;
    logic         exp_sticky;
    int           checks;
    int           errors;

    assign b_reg_data = reg_data[95:0];
    assign b_lock     = lock_status[5:0];

    locked_reg_read_port dut (
        .Clk            (Clk),
        .resetn         (resetn),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_ready      (rsp_ready),
        .reg_data       (reg_data),
        .lock_status    (lock_status),
        .scan_mode      (scan_mode),
        .debug_unlocked (debug_unlocked),
        .clr_viol       (clr_viol),
        .viol_count     (viol_count),
        .viol_sticky    (viol_sticky)
    );

    locked_reg_read_port #(.NUM_REGS(6)) dut_b (
        .Clk            (Clk),
        .resetn         (resetn),
        .req_valid      (b_req_valid),
        .req_addr       (b_req_addr),
        .req_ready      (b_req_ready),
        .rsp_valid      (b_rsp_valid),
        .rsp_data       (b_rsp_data),
        .rsp_err        (b_rsp_err),
        .rsp_ready      (b_rsp_ready),
        .reg_data       (b_reg_data),
        .lock_status    (b_lock),
        .scan_mode      (scan_mode),
        .debug_unlocked (debug_unlocked),
        .clr_viol       (clr_viol),
        .viol_count     (b_viol_count),
        .viol_sticky    (b_viol_sticky)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one request, predict its response and the telemetry, step through FETCH
    task automatic send_req(input int a, input bit clr_in_fetch);
        exp_t e;
        logic oob_m, lock_m, deny_m;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = 3'(a);
        oob_m  = (a >= 8);
        lock_m = !oob_m && mask_tb[a] && lock_status[a] && !debug_unlocked;
        deny_m = scan_mode || oob_m || lock_m;
        e.data = deny_m ? 16'h0 : regs[a];
        e.err  = deny_m;
        sb.push_back(e);
        if (clr_in_fetch) begin
            exp_cnt    = 0;
            exp_sticky = 1'b0;
        end else if (scan_mode || lock_m) begin
            exp_sticky = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
        end
        @(posedge Clk); #1;
        req_valid = 1'b0;
        if (clr_in_fetch) clr_viol = 1'b1;
        chk("fetch_req_ready", {31'b0, req_ready}, 32'd0);
        chk("fetch_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    endtask

    // Bounded wait for the response, then score it
    task automatic wait_rsp();
        exp_t e;
        int   n;
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(posedge Clk); #1;
            n++;
        end
        clr_viol = 1'b0;
        chk("rsp_latency", 32'(n), 32'd1);
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        end
        chk("viol_count", {24'b0, viol_count}, 32'(exp_cnt));
        chk("viol_sticky", {31'b0, viol_sticky}, {31'b0, exp_sticky});
    endtask

    // Full read with rsp_ready high: handshake then back to IDLE
    task automatic read_txn(input int a, input bit clr_in_fetch);
        send_req(a, clr_in_fetch);
        wait_rsp();
        @(posedge Clk); #1;
        chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] held;
        int          n;
        checks = 0;
        errors = 0;
        exp_cnt = 0;
        exp_sticky = 1'b0;
        mask_tb = 8'hF0;
        for (int i = 0; i < 8; i++) begin
            regs[i] = (i == 1) ? 16'h1234 : (16'hA000 | 16'(i * 16'h0111));
            reg_data[i*16 +: 16] = regs[i];
        end
        resetn = 1'b0;
        req_valid = 1'b0;
        req_addr = 3'd0;
        rsp_ready = 1'b1;
        lock_status = 8'hFF;
        scan_mode = 1'b0;
        debug_unlocked = 1'b0;
        clr_viol = 1'b0;
        b_req_valid = 1'b0;
        b_req_addr = 3'd0;
        b_rsp_ready = 1'b1;

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_viol_count", {24'b0, viol_count}, 32'd0);
        chk("rst_viol_sticky", {31'b0, viol_sticky}, 32'd0);
        resetn = 1'b1;
        @(posedge Clk); #1;

        // Non-secret locked register is readable
        read_txn(1, 1'b0);
        // Secret locked, no debug: denied and counted
        read_txn(5, 1'b0);
        // Debug authorisation overrides the lock
        debug_unlocked = 1'b1;
        read_txn(5, 1'b0);
        debug_unlocked = 1'b0;
        // Secret but unlocked
        lock_status[7] = 1'b0;
        read_txn(7, 1'b0);
        lock_status[7] = 1'b1;
        // Scan denies even a non-secret register
        scan_mode = 1'b1;
        read_txn(2, 1'b0);
        scan_mode = 1'b0;

        // Scan rising while the response is held
        rsp_ready = 1'b0;
        send_req(1, 1'b0);
        wait_rsp();
        scan_mode = 1'b1;
        @(posedge Clk); #1;
        chk("scan_resp_data", {16'b0, rsp_data}, 32'd0);
        chk("scan_resp_err", {31'b0, rsp_err}, 32'd1);
        chk("scan_resp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("scan_resp_count", {24'b0, viol_count}, 32'(exp_cnt));
        scan_mode = 1'b0;
        rsp_ready = 1'b1;
        @(posedge Clk); #1;
        chk("scan_resp_done", {31'b0, rsp_valid}, 32'd0);

        // Address 7 on a six-register bank: range error, not counted
        b_req_valid = 1'b1;
        b_req_addr = 3'd7;
        @(posedge Clk); #1;
        b_req_valid = 1'b0;
        n = 0;
        while (!b_rsp_valid && n < 8) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("oob_latency", 32'(n), 32'd1);
        chk("oob_err", {31'b0, b_rsp_err}, 32'd1);
        chk("oob_data", {16'b0, b_rsp_data}, 32'd0);
        chk("oob_count", {24'b0, b_viol_count}, 32'd0);
        chk("oob_sticky", {31'b0, b_viol_sticky}, 32'd0);
        @(posedge Clk); #1;

        // Held response: stable data, no acceptance, immune to policy changes
        rsp_ready = 1'b0;
        debug_unlocked = 1'b1;
        send_req(6, 1'b0);
        wait_rsp();
        held = rsp_data;
        debug_unlocked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            chk("hold_data", {16'b0, rsp_data}, {16'b0, regs[6]});
            chk("hold_err", {31'b0, rsp_err}, 32'd0);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        chk("hold_first_data", {16'b0, held}, {16'b0, regs[6]});
        rsp_ready = 1'b1;
        @(posedge Clk); #1;

        // Saturation after 260 denials
        for (int i = 0; i < 260; i++) begin
            read_txn(4, 1'b0);
        end
        chk("sat_count", {24'b0, viol_count}, 32'd255);

        // Clear coinciding with a denied FETCH
        read_txn(5, 1'b1);
        chk("clr_count", {24'b0, viol_count}, 32'd0);
        chk("clr_sticky", {31'b0, viol_sticky}, 32'd0);

        // Reset while a response is pending
        read_txn(5, 1'b0);
        rsp_ready = 1'b0;
        send_req(0, 1'b0);
        wait_rsp();
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_count", {24'b0, viol_count}, 32'd0);
        chk("rst_mid_data", {16'b0, rsp_data}, 32'd0);
        exp_cnt = 0;
        exp_sticky = 1'b0;
        sb.delete();
        @(posedge Clk); #1;
        resetn = 1'b1;
        rsp_ready = 1'b1;
        @(posedge Clk); #1;
        read_txn(3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/locked_reg_read_port.md
# locked_reg_read_port

Read-side responder for the bank of lockable 16-bit configuration registers. It accepts read requests over a valid/ready handshake, selects one register, applies the lock/debug/scan access policy, and returns data with an error flag. It sits between the register bank's lock-status outputs and the debug/config bus, and counts denied accesses for security telemetry.

## Interface
Parameters:
- NUM_REGS, 8, number of registers in the bank
- DATA_W, 16, register width
- ADDR_W, 3, request address width; must satisfy 2**ADDR_W >= NUM_REGS
- SECRET_MASK, 8'hF0, bit i=1 marks register i as secret (readable only when unlocked)

Ports:
- Clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  read request valid
- req_addr  in  ADDR_W  register index
- req_ready  out  1  block can accept a request
- rsp_valid  out  1  response valid
- rsp_data  out  DATA_W  read data; 0 on any error
- rsp_err  out  1  access denied or address out of range
- rsp_ready  in  1  consumer accepts response
- reg_data  in  NUM_REGS*DATA_W  flattened register contents; reg i at [i*DATA_W +: DATA_W]
- lock_status  in  NUM_REGS  per-register lock bits from the bank
- scan_mode  in  1  scan active; all reads denied
- debug_unlocked  in  1  debug authorisation; overrides lock for secret registers
- clr_viol  in  1  synchronous clear of violation counter and sticky flag
- viol_count  out  8  saturating count of denied reads
- viol_sticky  out  1  set on first denied read, held until clr_viol

## Operation
- FSM states: IDLE, FETCH, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_addr, go to FETCH.
- FETCH: req_ready=0. Evaluate the policy, register rsp_data/rsp_err, update the violation counters, go to RESP.
- RESP: rsp_valid=1, with rsp_data/rsp_err held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE. No back-to-back acceptance: the next request is accepted no earlier than the cycle after the response handshake.
- Denial is decided in FETCH and is true when any of the following hold: scan_mode=1; addr >= NUM_REGS; SECRET_MASK[addr] && lock_status[addr] && !debug_unlocked.
  - Denied: rsp_data=0, rsp_err=1. Not denied: rsp_data=reg i, rsp_err=0.
- Non-secret registers are always readable outside scan_mode, regardless of lock state.
- Violation accounting happens on the FETCH->RESP edge, only when the read is denied for scan or lock reasons. Out-of-range addresses set rsp_err but are not counted.
  - viol_count increments by 1 and saturates at 255.
  - viol_sticky is set to 1.
- clr_viol has priority over a simultaneous increment: the result is count=0, sticky=0.
- scan_mode asserting while in RESP: on the next edge rsp_data is forced to 0 and rsp_err to 1. rsp_valid stays high, and nothing is counted.
- lock_status or debug_unlocked changing during RESP does not alter the held response. The policy is sampled only in FETCH.

## Timing
- Reset values: req_ready=1 (state IDLE), rsp_valid=0, rsp_data=0, rsp_err=0, viol_count=0, viol_sticky=0.
- Latency: request accepted at edge N; rsp_valid is high from edge N+2 onward.
- Minimum throughput is one read per 3 cycles with rsp_ready tied high.
- resetn asserted mid-transaction: immediate return to IDLE, all outputs take their reset values, and the pending response is dropped.
- All outputs are registered; there are no combinational paths from inputs to outputs except none. req_ready decodes directly from the state register.

## Structure
- Package locked_reg_pkg holds:
  - the state enum {IDLE, FETCH, RESP}
  - VIOL_CNT_W=8 and VIOL_CNT_MAX=8'hFF
  - the default SECRET_MASK constant.
- Sub-module lock_access_check is purely combinational: inputs addr, lock_status, scan_mode, debug_unlocked, with SECRET_MASK as a parameter; outputs deny, count_viol, oob. It is shared with the write-side lock logic for policy consistency.

## Test plan
- Reset, then read reg 1 (non-secret, locked, reg=16'h1234), rsp_ready=1 -> rsp_valid at N+2, data 16'h1234, err 0, viol_count 0.
- Read reg 5 (secret) with lock_status[5]=1, debug_unlocked=0 -> data 0, err 1, viol_count 1, viol_sticky 1. Repeat with debug_unlocked=1 -> real data, err 0, count unchanged.
- scan_mode=1, read reg 2 -> data 0, err 1, count increments. Separately, hold rsp_ready=0 in RESP and raise scan_mode -> next cycle data 0, err 1, rsp_valid stays 1.
- Read address 7 with NUM_REGS=6 -> err 1, data 0, count unchanged.
- Issue 260 denied reads -> viol_count saturates at 255. Pulse clr_viol in the same cycle as a denied FETCH -> count 0, sticky 0.
- Hold rsp_ready=0 for 5 cycles -> rsp_data stable and req_ready=0 throughout. Pulse resetn low mid-RESP -> rsp_valid=0 immediately and req_ready=1.
